// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width, default buffer
// depth and the launch sequencer state encoding.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Launch sequencer states. GAP absorbs the transmitter's cleanup cycle,
  // during which a launch pulse would be ignored.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_ACTIVE = 2'd1,
    ST_WAIT_DONE   = 2'd2,
    ST_GAP         = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with registered count, full and empty flags.
// Writes while full and reads while empty are ignored.
module byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1'b1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1'b1);
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_r;
  logic [ADDR_W-1:0]      rd_ptr_r;
  logic [ADDR_W:0]        count_r;
  logic                   full_r;
  logic                   empty_r;
  logic                   push_ok_s;
  logic                   pop_ok_s;
  logic [ADDR_W:0]        count_next_s;

  // Qualify requests against the registered flags and derive the next occupancy.
  always_comb begin
    push_ok_s    = push && !full_r;
    pop_ok_s     = pop && !empty_r;
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; written only on an accepted push, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH; flags are registered from next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_DEPTH);
      empty_r <= (count_next_s == CNT_ZERO);
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch sequencer in front of uart_tx. Bytes are queued at
// clock rate and launched one at a time, paced on the transmitter's
// active/done status so the producer never sees UART bit timing.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Wr_En,
  input  logic [UART_DATA_W-1:0] i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Overflow,
  output logic                   o_Busy,
  output logic                   o_Tx_DV,
  output logic [UART_DATA_W-1:0] o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done
);

  feeder_state_t          state_r;
  logic                   tx_dv_r;
  logic [UART_DATA_W-1:0] tx_byte_r;
  logic                   overflow_r;
  logic                   busy_r;

  logic                   pop_s;
  logic                   wr_ok_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [UART_DATA_W-1:0] fifo_rd_data_s;
  logic [ADDR_W:0]        fifo_count_s;

  // The head is popped only from IDLE; a write is taken only if not full at this edge.
  assign pop_s   = (state_r == ST_IDLE) && !fifo_empty_s;
  assign wr_ok_s = i_Wr_En && !fifo_full_s;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_Clock),
    .rst_n   (i_Rst_n),
    .push    (i_Wr_En),
    .pop     (pop_s),
    .wr_data (i_Wr_Byte),
    .rd_data (fifo_rd_data_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Launch sequencer with registered DV, byte, overflow and busy outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r    <= ST_IDLE;
      tx_dv_r    <= 1'b0;
      tx_byte_r  <= {UART_DATA_W{1'b0}};
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      tx_dv_r    <= 1'b0;
      overflow_r <= i_Wr_En && fifo_full_s;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r   <= ST_WAIT_ACTIVE;
            tx_dv_r   <= 1'b1;
            tx_byte_r <= fifo_rd_data_s;
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= wr_ok_s;
          end
        end
        ST_WAIT_ACTIVE: begin
          state_r <= i_Tx_Active ? ST_WAIT_DONE : ST_WAIT_ACTIVE;
          busy_r  <= 1'b1;
        end
        ST_WAIT_DONE: begin
          state_r <= i_Tx_Done ? ST_GAP : ST_WAIT_DONE;
          busy_r  <= 1'b1;
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
          busy_r  <= !fifo_empty_s || wr_ok_s;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= !fifo_empty_s || wr_ok_s;
        end
      endcase
    end
  end

  assign o_Full     = fifo_full_s;
  assign o_Empty    = fifo_empty_s;
  assign o_Count    = fifo_count_s;
  assign o_Overflow = overflow_r;
  assign o_Busy     = busy_r;
  assign o_Tx_DV    = tx_dv_r;
  assign o_Tx_Byte  = tx_byte_r;

endmodule
